led_chaser: RTL and testbench

//  Parametrised successor of the 4-LED shift pipe. Drives an N_LED-wide LED

---
 rtl/led_chaser_if.sv | 23 ++
 rtl/led_chaser.sv | 95 +++++++++
 tb/tb_led_chaser.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/led_chaser_if.sv
// Control/status bundle between the board-level controller and the LED chaser.
// The controller drives the mode and load strobes; the chaser returns pattern and status.
interface led_chaser_if #(
  parameter int unsigned N_LED = 8
);
  logic             enable;
  logic [1:0]       mode;
  logic             load;
  logic [N_LED-1:0] load_data;
  logic [N_LED-1:0] diode;
  logic             step;
  logic             dir;

  modport master (
    output enable, mode, load, load_data,
    input  diode, step, dir
  );

  modport slave (
    input  enable, mode, load, load_data,
    output diode, step, dir
  );
endinterface

// File: rtl/led_chaser.sv
// Prescaled LED pattern generator: rotate-left/right, bounce and hold, with a
// synchronous pattern load that overrides any coincident prescaler tick.
module led_chaser #(
  parameter int unsigned N_LED         = 8,
  parameter int unsigned DIV           = 4,
  parameter int unsigned RESET_PATTERN = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  led_chaser_if.slave bus
);

  localparam int unsigned     CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
  localparam logic [N_LED-1:0] RST_PAT = N_LED'(RESET_PATTERN);

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'b00,
    MODE_ROTR   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  logic [CW-1:0]    r_cnt;
  logic [N_LED-1:0] r_diode;
  logic             r_dir;
  logic             r_step;
  logic             w_tick;
  mode_t            w_mode;

  function automatic logic [N_LED-1:0] rot_left(input logic [N_LED-1:0] v);
    return {v[N_LED-2:0], v[N_LED-1]};
  endfunction

  function automatic logic [N_LED-1:0] rot_right(input logic [N_LED-1:0] v);
    return {v[0], v[N_LED-1:1]};
  endfunction

  assign w_mode = mode_t'(bus.mode);
  assign w_tick = bus.enable && (r_cnt == CNT_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_diode <= RST_PAT;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
    end else if (bus.load) begin
      // Load restarts the prescaler so the next shift is a full DIV clocks away.
      r_diode <= bus.load_data;
      r_cnt   <= '0;
      r_step  <= 1'b0;
    end else if (bus.enable) begin
      r_cnt  <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);
      r_step <= 1'b0;
      if (w_tick) begin
        case (w_mode)
          MODE_ROTL: begin
            r_diode <= rot_left(r_diode);
            r_dir   <= 1'b0;
            r_step  <= 1'b1;
          end
          MODE_ROTR: begin
            r_diode <= rot_right(r_diode);
            r_dir   <= 1'b1;
            r_step  <= 1'b1;
          end
          MODE_BOUNCE: begin
            // Zero-fill shifts: the end LED turns the direction around.
            r_step <= 1'b1;
            if (!r_dir && r_diode[N_LED-1]) begin
              r_dir   <= 1'b1;
              r_diode <= r_diode >> 1;
            end else if (r_dir && r_diode[0]) begin
              r_dir   <= 1'b0;
              r_diode <= r_diode << 1;
            end else if (r_dir) begin
              r_diode <= r_diode >> 1;
            end else begin
              r_diode <= r_diode << 1;
            end
          end
          default: r_step <= 1'b0;
        endcase
      end
    end else begin
      r_step <= 1'b0;
    end
  end

  assign bus.diode = r_diode;
  assign bus.step  = r_step;
  assign bus.dir   = r_dir;

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser: DIV=4 and DIV=1 instances share stimulus and are checked
// every cycle against an arithmetic reference model of the pattern behaviour.
module tb_led_chaser;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [7:0] load_data = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state for instance 0 (DIV=4) and instance 1 (DIV=1).
  int m_pat  [2];
  int m_cnt  [2];
  int m_dir  [2];
  int m_step [2];
  int m_div  [2] = '{4, 1};

  always #20 clock = ~clock;

  led_chaser_if #(.N_LED(8)) bus0 ();
  led_chaser_if #(.N_LED(8)) bus1 ();

  assign bus0.enable = enable;    assign bus1.enable = enable;
  assign bus0.mode = mode;        assign bus1.mode = mode;
  assign bus0.load = load;        assign bus1.load = load;
  assign bus0.load_data = load_data; assign bus1.load_data = load_data;

  led_chaser #(.N_LED(8), .DIV(4), .RESET_PATTERN(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0.slave)
  );
  led_chaser #(.N_LED(8), .DIV(1), .RESET_PATTERN(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1.slave)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pat[k] = 1; m_cnt[k] = 0; m_dir[k] = 0; m_step[k] = 0;
    end
  endtask

  // One rising edge of the reference, computed from the current inputs.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit tick;
      tick = (m_cnt[k] == m_div[k] - 1);
      m_step[k] = 0;
      if (load) begin
        m_pat[k] = load_data;
        m_cnt[k] = 0;
      end else if (enable) begin
        m_cnt[k] = (m_cnt[k] + 1) % m_div[k];
        if (tick && mode != 2'b11) begin
          m_step[k] = 1;
          if (mode == 2'b00) begin
            m_pat[k] = (m_pat[k] * 2) % 256 + m_pat[k] / 128;
            m_dir[k] = 0;
          end else if (mode == 2'b01) begin
            m_pat[k] = m_pat[k] / 2 + (m_pat[k] % 2) * 128;
            m_dir[k] = 1;
          end else if (m_dir[k] == 0 && m_pat[k] >= 128) begin
            m_dir[k] = 1;
            m_pat[k] = m_pat[k] / 2;
          end else if (m_dir[k] == 1 && m_pat[k] % 2 == 1) begin
            m_dir[k] = 0;
            m_pat[k] = (m_pat[k] * 2) % 256;
          end else begin
            m_pat[k] = (m_dir[k] != 0) ? m_pat[k] / 2 : (m_pat[k] * 2) % 256;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_diode4"}, int'(bus0.diode), m_pat[0]);
    check_eq({tag, "_dir4"},   int'(bus0.dir),   m_dir[0]);
    check_eq({tag, "_step4"},  int'(bus0.step),  m_step[0]);
    check_eq({tag, "_diode1"}, int'(bus1.diode), m_pat[1]);
    check_eq({tag, "_dir1"},   int'(bus1.dir),   m_dir[1]);
    check_eq({tag, "_step1"},  int'(bus1.step),  m_step[1]);
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  // Reset pulse placed between clock edges; called right after a check point.
  task automatic pulse_reset(input string tag);
    #9 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all({tag, "_async"});
    #10 reset_n = 1'b1;
  endtask

  initial begin
    // Asynchronous reset applied between edges, checked before and after an edge.
    #10 reset_n = 1'b0;
    #5;
    model_reset();
    compare_all("rst_pre_edge");
    #10;
    compare_all("rst_held");
    #5 reset_n = 1'b1;

    // Rotate left from reset: first change at the DIV-th enabled edge.
    enable = 1'b1;
    mode   = 2'b00;
    for (int i = 0; i < 3; i++) cycle("rotl_lat");
    check_eq("lat_hold", int'(bus0.diode), 8'h01);
    cycle("rotl_lat");
    check_eq("lat_first", int'(bus0.diode), 8'h02);
    check_eq("lat_step", int'(bus0.step), 1);
    for (int i = 0; i < 32; i++) cycle("rotl");
    check_eq("rotl_wrap", int'(bus0.diode), 8'h02);

    // Bounce across both ends twice.
    mode = 2'b10;
    for (int i = 0; i < 70; i++) cycle("bounce");

    // Freeze mid-count.
    while (m_cnt[0] != 2) cycle("align");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cycle("freeze");
    enable = 1'b1;
    cycle("resume");
    check_eq("resume_nostep", int'(bus0.step), 0);
    cycle("resume");
    check_eq("resume_step", int'(bus0.step), 1);

    // Load on a tick cycle drops the shift.
    mode = 2'b01;
    while (m_cnt[0] != 3) cycle("align");
    load = 1'b1;
    load_data = 8'hA5;
    cycle("load");
    check_eq("load_val", int'(bus0.diode), 8'hA5);
    load = 1'b0;
    for (int i = 0; i < 4; i++) cycle("after_load");
    check_eq("load_next", int'(bus0.diode), 8'hD2);

    // Hold mode: no motion, no step.
    mode = 2'b11;
    for (int i = 0; i < 8; i++) cycle("hold");

    // Mid-run reset, then restart.
    mode = 2'b00;
    for (int i = 0; i < 5; i++) cycle("pre_rst");
    pulse_reset("midrst");
    cycle("post_rst");
    check_eq("restart_div1", int'(bus1.diode), 8'h02);

    // Randomised run.
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 9) < 8);
      load      = ($urandom_range(0, 19) == 0);
      load_data = 8'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
